// File: rtl/program_counter_pkg.sv
// Shared fetch-stage constants: PC width, instruction size and PC function-select encodings.
package program_counter_pkg;

   localparam int unsigned PC_WIDTH    = 64;
   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [1:0] PS_HOLD   = 2'b00;
   localparam logic [1:0] PS_INC    = 2'b01;
   localparam logic [1:0] PS_LOAD   = 2'b10;
   localparam logic [1:0] PS_BRANCH = 2'b11;

endpackage : program_counter_pkg

// File: rtl/program_counter_pc_next_logic.sv
// Combinational next-PC selection: hold, increment, absolute load or PC-relative branch.
module pc_next_logic
   import program_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = PC_WIDTH,
   parameter int unsigned INSTR_BYTES = program_counter_pkg::INSTR_BYTES
) (
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       ps,
   output logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] pc_plus4
);

   // Branch displacement is in instruction units; scaling drops the top bits of in.
   localparam int unsigned OFFSET_SHIFT = $clog2(INSTR_BYTES);

   logic [WIDTH-1:0] offset;

   // Select the next PC; all sums wrap modulo 2^WIDTH.
   always_comb begin
      pc_plus4 = pc + WIDTH'(INSTR_BYTES);
      offset   = in << OFFSET_SHIFT;
      next_pc  = pc;
      case (ps)
         PS_HOLD:   next_pc = pc;
         PS_INC:    next_pc = pc_plus4;
         PS_LOAD:   next_pc = in;
         PS_BRANCH: next_pc = pc_plus4 + offset;
         default:   next_pc = 'x;
      endcase
   end

endmodule : pc_next_logic

// File: rtl/program_counter.sv
// Fetch-stage program counter: asynchronously reset PC register plus combinational PC+4.
module program_counter
   import program_counter_pkg::*;
#(
   parameter int unsigned       WIDTH       = PC_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_PC    = '0,
   parameter int unsigned       INSTR_BYTES = program_counter_pkg::INSTR_BYTES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       PS,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC4
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] next_pc;
   logic [WIDTH-1:0] pc_plus4;

   pc_next_logic #(
      .WIDTH       (WIDTH),
      .INSTR_BYTES (INSTR_BYTES)
   ) u_next (
      .pc       (pc_q),
      .in       (in),
      .ps       (PS),
      .next_pc  (next_pc),
      .pc_plus4 (pc_plus4)
   );

   // PC register; reset low forces RESET_PC immediately and holds it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= next_pc;
      end
   end

   assign PC  = pc_q;
   assign PC4 = pc_plus4;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
module tb_program_counter;
   import program_counter_pkg::*;

   logic        clock;
   logic        reset;
   logic [63:0] in_v;
   logic [1:0]  ps;
   logic [63:0] pc;
   logic [63:0] pc4;

   int checks   = 0;
   int failures = 0;

   program_counter #(
      .WIDTH       (64),
      .RESET_PC    (64'h0),
      .INSTR_BYTES (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .in    (in_v),
      .PS    (ps),
      .PC    (pc),
      .PC4   (pc4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply PS/in at a falling edge, let one rising edge pass, return at the next falling edge.
   task automatic step(input logic [1:0] p, input logic [63:0] v);
      ps   = p;
      in_v = v;
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b0;
      ps    = PS_INC;
      in_v  = 64'd0;
      #1;
      check("reset_pc_noclk", pc, 64'd0);
      check("reset_pc4_noclk", pc4, 64'd4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("reset_pc_hold", pc, 64'd0);
         check("reset_pc4_hold", pc4, 64'd4);
      end

      // Release reset, load unaligned 10, then hold.
      reset = 1'b1;
      step(PS_LOAD, 64'd10);
      check("load_pc", pc, 64'd10);
      check("load_pc4", pc4, 64'd14);
      step(PS_HOLD, 64'd99);
      check("hold1_pc", pc, 64'd10);
      step(PS_HOLD, 64'd77);
      check("hold2_pc", pc, 64'd10);

      // Sequential increments.
      step(PS_INC, 64'd0);
      check("inc1_pc", pc, 64'd14);
      check("inc1_pc4", pc4, 64'd18);
      step(PS_INC, 64'd0);
      check("inc2_pc", pc, 64'd18);

      // Relative branches, forward and backward, from PC=14.
      step(PS_LOAD, 64'd14);
      check("reload_pc", pc, 64'd14);
      step(PS_BRANCH, 64'd10);
      check("br_fwd_pc", pc, 64'd58);
      check("br_fwd_pc4", pc4, 64'd62);
      step(PS_BRANCH, 64'hFFFF_FFFF_FFFF_FFFC);
      check("br_back_pc", pc, 64'd46);

      // Offset top bits are discarded by the scaling shift.
      step(PS_BRANCH, 64'h4000_0000_0000_0001);
      check("br_shift_drop", pc, 64'd54);

      // Wrap-around.
      step(PS_LOAD, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_load_pc4", pc4, 64'd0);
      step(PS_INC, 64'd0);
      check("wrap_inc_pc", pc, 64'd0);
      check("wrap_inc_pc4", pc4, 64'd4);
      step(PS_LOAD, 64'hFFFF_FFFF_FFFF_FFF8);
      step(PS_BRANCH, 64'd1);
      check("wrap_br_pc", pc, 64'd0);

      // Mixed sequence then asynchronous reset between edges.
      step(PS_INC, 64'($urandom));
      check("mix_inc_pc", pc, 64'd4);
      step(PS_BRANCH, 64'd2);
      check("mix_br_pc", pc, 64'd16);
      step(PS_INC, 64'($urandom));
      check("mix_inc2_pc", pc, 64'd20);
      ps   = PS_BRANCH;
      in_v = 64'd5;
      #2 reset = 1'b0;
      #1;
      check("async_rst_pc", pc, 64'd0);
      check("async_rst_pc4", pc4, 64'd4);
      @(posedge clock);
      #1;
      check("rst_over_ps", pc, 64'd0);
      @(negedge clock);
      reset = 1'b1;
      step(PS_INC, 64'($urandom));
      check("resume_inc_pc", pc, 64'd4);

      // Half-cycle reset pulse during the high phase.
      step(PS_BRANCH, 64'd1);
      check("pre_pulse_pc", pc, 64'd12);
      ps = PS_INC;
      @(posedge clock);
      #1;
      check("pre_pulse_edge_pc", pc, 64'd16);
      reset = 1'b0;
      #1;
      check("pulse_pc", pc, 64'd0);
      @(negedge clock);
      reset = 1'b1;
      step(PS_INC, 64'($urandom));
      check("pulse_resume_pc", pc, 64'd4);
      check("pulse_resume_pc4", pc4, 64'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_program_counter

// File: doc/program_counter.md
Name: program_counter

Overview:
- 64-bit program counter register for the CPU fetch stage.
- Each rising clock edge it updates from one of four sources under a 2-bit function select: hold, sequential increment, absolute load, or PC-relative branch.
- Continuously exposes the current PC and PC+4, used for instruction fetch, link-register writeback and branch-target formation.

Parameters:
- WIDTH, 64, width of PC, PC4 and in.
- RESET_PC, 0, value loaded into PC while reset is asserted.
- INSTR_BYTES, 4, sequential increment in bytes; branch offsets are scaled by the same amount.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- PC  output  WIDTH  current program counter (registered).
- PC4  output  WIDTH  PC + 4, combinational from the PC register.
- in  input  WIDTH  load address (PS=10) or word-offset branch displacement (PS=11).
- PS  input  2  function select: 00 hold, 01 increment, 10 load, 11 relative branch.

Behaviour:
- Reset:
  - reset low forces PC = RESET_PC (0) immediately, with no clock required.
  - Therefore PC4 = 4 while in reset.
  - While reset is low, PC stays at RESET_PC regardless of PS, in or clock.
  - Deassertion (reset high) takes effect at the next rising clock edge.
- Each rising clock edge with reset high updates PC by PS:
  - 00: PC <= PC (hold).
  - 01: PC <= PC + 4.
  - 10: PC <= in.
  - 11: PC <= PC + 4 + (in << 2).
- Latency:
  - A new PC is visible one clock after PS/in are sampled.
  - PC4 tracks PC in the same cycle with zero latency.
- Arithmetic:
  - All sums are modulo 2^WIDTH; carries are discarded.
  - in << 2 drops the top 2 bits of in.
  - in is interpreted as two's complement, so negative offsets branch backward naturally under modulo arithmetic.
- Wrap-around: PC = 0xFFFF_FFFF_FFFF_FFFC with PS=01 gives PC = 0 and PC4 = 4. No overflow flag is produced.
- PS or in containing X/Z: PC becomes X in simulation. No recovery logic is required; upstream must drive valid values.
- Alignment: no check is made that in or PC is 4-byte aligned. A load of an unaligned value (e.g. 10) is stored verbatim.
- Reset asserted mid-operation: PC returns to 0 asynchronously, overriding any PS in progress.
- No other state; no outputs besides PC and PC4.

Decomposition:
- Shared CPU package holds:
  - PS encodings as named constants: PS_HOLD=2'b00, PS_INC=2'b01, PS_LOAD=2'b10, PS_BRANCH=2'b11.
  - INSTR_BYTES and the default WIDTH.
- One natural sub-module: pc_next_logic. It is purely combinational, takes PC, in and PS, and returns next_pc and pc_plus4.
- The top level holds only the asynchronous-reset register and the PC4 output.

Test Plan:
- Reset: drive reset=0 with PS=01 for 3 clocks -> PC=0 and PC4=4 throughout. Assert reset between clock edges -> PC=0 before the next edge.
- Load and hold: release reset; PS=10, in=10 for 1 edge -> PC=10, PC4=14. Then PS=00 for 2 edges -> PC remains 10.
- Increment: from PC=10, PS=01 for 1 edge -> PC=14, PC4=18. A second edge gives PC=18.
- Relative branch: from PC=14, PS=11, in=10 -> PC=14+4+40=58. With in=-4 (all ones except 0b00 low...FFFC) from PC=58 -> PC=58+4-16=46.
- Wrap: load PC=0xFFFF_FFFF_FFFF_FFFC, then PS=01 -> PC=0, PC4=4. Load 0xFFFF_FFFF_FFFF_FFF8, PS=11, in=1 -> PC=0.
- Reset mid-sequence: alternate PS=01/11 with random in; pulse reset low for half a cycle -> PC=0 immediately, and increments resume from 0 on the first edge after release.
